// File: rtl/bug_motion_ctl.sv
// ---------------------------------------------------------------------------
// bug_motion_ctl
//
// Motion and game controller for the bug sprite. The bug moves once per
// frame, on the rising edge of vblnk_in, and bounces off the screen borders.
// A left click on the bug freezes it for SQUASH_FRAMES frames and adds one to
// a saturating score. The bug then respawns at a pseudo-random position
// taken from a free-running LFSR.
//
// Optional feature, selected with the macro BUG_SPEEDUP_EN:
//   When the macro is defined, the per-frame step grows with the score
//   (STEP + score[7:2]) and is capped at 2*STEP.
//   When it is undefined, the step is always STEP.
//
// Ports:
//   pclk        in   1   pixel clock
//   reset       in   1   synchronous, active-high reset
//   vblnk_in    in   1   vertical blank; its rising edge is the frame tick
//   start       in   1   one-cycle pulse that leaves IDLE
//   mouse_xpos  in  12   mouse x
//   mouse_ypos  in  12   mouse y
//   mouse_left  in   1   left button level
//   x_bugpos    out 12   bug left edge (registered)
//   y_bugpos    out 12   bug top edge (registered)
//   score       out  8   hit count, saturating at 255
//   squashed    out  1   high while the bug is frozen after a hit
// ---------------------------------------------------------------------------
module bug_motion_ctl #(
   parameter int SCREEN_W      = 1024,
   parameter int SCREEN_H      = 768,
   parameter int BUG_W         = 50,
   parameter int BUG_H         = 54,
   parameter int STEP          = 4,
   parameter int SQUASH_FRAMES = 30,
   parameter int X_INIT        = 0,
   parameter int Y_INIT        = 0
) (
   input  logic        pclk,
   input  logic        reset,
   input  logic        vblnk_in,
   input  logic        start,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   output logic [11:0] x_bugpos,
   output logic [11:0] y_bugpos,
   output logic [7:0]  score,
   output logic        squashed
);

   localparam logic [11:0] XMAX     = 12'(SCREEN_W - BUG_W);
   localparam logic [11:0] YMAX     = 12'(SCREEN_H - BUG_H);
   localparam logic [11:0] BUG_W_12 = 12'(BUG_W);
   localparam logic [11:0] BUG_H_12 = 12'(BUG_H);
   localparam logic [15:0] CNT_INIT = 16'(SQUASH_FRAMES);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MOVING   = 2'd1,
      SQUASHED = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic        vblnk_q_reg;
   logic        left_q_reg;
   logic [11:0] x_reg, x_next;
   logic [11:0] y_reg, y_next;
   // Direction bits: 1 = right (x) / down (y), 0 = left / up.
   logic        dir_x_reg, dir_x_next;
   logic        dir_y_reg, dir_y_next;
   logic [7:0]  score_reg, score_next;
   logic [15:0] cnt_reg, cnt_next;
   logic [15:0] lfsr_reg;

   logic        tick;
   logic        click_edge;
   logic        on_bug;
   logic        hit;
   logic [11:0] step_eff;
   logic [11:0] spawn_x_raw, spawn_y_raw;
   logic [11:0] spawn_x, spawn_y;
   logic        lfsr_fb;

   assign tick       = vblnk_in & ~vblnk_q_reg;
   assign click_edge = mouse_left & ~left_q_reg;

   // Bounding box test against the current registered position.
   assign on_bug = (mouse_xpos >= x_reg) && (mouse_xpos < x_reg + BUG_W_12) &&
                   (mouse_ypos >= y_reg) && (mouse_ypos < y_reg + BUG_H_12);
   assign hit    = (state_reg == MOVING) && click_edge && on_bug;

`ifdef BUG_SPEEDUP_EN
   logic [11:0] step_raw;
   assign step_raw = 12'(STEP) + {6'd0, score_reg[7:2]};
   assign step_eff = (step_raw > 12'(2 * STEP)) ? 12'(2 * STEP) : step_raw;
`else
   assign step_eff = 12'(STEP);
`endif

   // Fibonacci LFSR, taps 16,14,13,11 (maximal length, so never all-zero).
   assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

   // Respawn: fold the 10-bit random field back into the legal range.
   assign spawn_x_raw = {2'b00, lfsr_reg[9:0]};
   assign spawn_y_raw = {2'b00, lfsr_reg[15:6]};
   assign spawn_x     = (spawn_x_raw <= XMAX) ? spawn_x_raw : spawn_x_raw - XMAX;
   assign spawn_y     = (spawn_y_raw <= YMAX) ? spawn_y_raw : spawn_y_raw - YMAX;

   // One axis of motion; the limit test happens before any subtraction so
   // the 12-bit arithmetic never wraps.
   function automatic logic [11:0] axis_pos(input logic [11:0] p, input logic fwd,
                                            input logic [11:0] s, input logic [11:0] lim);
      if (fwd)
         return (p + s >= lim) ? lim : p + s;
      else
         return (p <= s) ? 12'd0 : p - s;
   endfunction

   function automatic logic axis_dir(input logic [11:0] p, input logic fwd,
                                     input logic [11:0] s, input logic [11:0] lim);
      if (fwd)
         return !(p + s >= lim);
      else
         return (p <= s);
   endfunction

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      dir_x_next = dir_x_reg;
      dir_y_next = dir_y_reg;
      score_next = score_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = MOVING;
         end
         MOVING: begin
            // A hit takes priority over a tick in the same cycle.
            if (hit) begin
               state_next = SQUASHED;
               score_next = (score_reg == 8'hFF) ? score_reg : score_reg + 8'd1;
               cnt_next   = CNT_INIT;
            end else if (tick) begin
               x_next     = axis_pos(x_reg, dir_x_reg, step_eff, XMAX);
               dir_x_next = axis_dir(x_reg, dir_x_reg, step_eff, XMAX);
               y_next     = axis_pos(y_reg, dir_y_reg, step_eff, YMAX);
               dir_y_next = axis_dir(y_reg, dir_y_reg, step_eff, YMAX);
            end
         end
         SQUASHED: begin
            if (tick) begin
               // A count of 0 (SQUASH_FRAMES = 0) behaves like 1.
               if (cnt_reg <= 16'd1) begin
                  state_next = MOVING;
                  cnt_next   = 16'd0;
                  x_next     = spawn_x;
                  y_next     = spawn_y;
                  dir_x_next = lfsr_reg[0];
                  dir_y_next = lfsr_reg[1];
               end else begin
                  cnt_next = cnt_reg - 16'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         state_reg   <= IDLE;
         vblnk_q_reg <= 1'b0;
         left_q_reg  <= 1'b0;
         x_reg       <= 12'(X_INIT);
         y_reg       <= 12'(Y_INIT);
         dir_x_reg   <= 1'b1;
         dir_y_reg   <= 1'b1;
         score_reg   <= 8'd0;
         cnt_reg     <= 16'd0;
         lfsr_reg    <= 16'hACE1;
      end else begin
         state_reg   <= state_next;
         vblnk_q_reg <= vblnk_in;
         left_q_reg  <= mouse_left;
         x_reg       <= x_next;
         y_reg       <= y_next;
         dir_x_reg   <= dir_x_next;
         dir_y_reg   <= dir_y_next;
         score_reg   <= score_next;
         cnt_reg     <= cnt_next;
         lfsr_reg    <= {lfsr_reg[14:0], lfsr_fb};
      end
   end

   assign x_bugpos = x_reg;
   assign y_bugpos = y_reg;
   assign score    = score_reg;
   assign squashed = (state_reg == SQUASHED);

endmodule
